// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the command-master state type.
// Imported by the command master and its lane-alignment helper.
package ahblite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  // Only byte/half/word transfers exist on this 32-bit bus, each naturally aligned.
  function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lo[0];
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahblite_lane_align.sv
// Byte-lane handling for a 32-bit AHB-Lite bus: write replication across
// lanes and right-justified, zero-extended extraction of read data.
module ahblite_lane_align
  import ahblite_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_aligned
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wlane
      assign wdata_lanes[gi*8 +: 8] =
        (size == HSIZE_BYTE) ? wdata[7:0] :
        (size == HSIZE_HALF) ? wdata[(gi % 2)*8 +: 8] :
                               wdata[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    rdata_aligned = '0;
    case (size)
      HSIZE_BYTE: rdata_aligned[7:0]  = rdata[{addr_lo, 3'b000} +: 8];
      HSIZE_HALF: rdata_aligned[15:0] = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      default:    rdata_aligned       = rdata;
    endcase
  end

endmodule

// File: rtl/ahblite_cmd_master.sv
// Single-outstanding AHB-Lite manager: turns one command at a time into a
// SINGLE transfer and reports completion with a one-cycle response pulse.
module ahblite_cmd_master
  import ahblite_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic        write_reg;
  logic [2:0]  size_reg;
  logic [31:0] wdata_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  htrans_t     htrans_next;
  logic [31:0] hwdata_next;
  logic [31:0] wdata_lanes;
  logic [31:0] rdata_aligned;
  logic        accept;
  logic        legal;
  logic        done;

  ahblite_lane_align u_lane_align (
    .size          (size_reg),
    .addr_lo       (addr_reg[1:0]),
    .wdata         (wdata_reg),
    .rdata         (HRDATA),
    .wdata_lanes   (wdata_lanes),
    .rdata_aligned (rdata_aligned)
  );

  assign accept = cmd_valid & cmd_ready;
  assign legal  = cmd_legal(cmd_size, cmd_addr[1:0]);
  assign done   = (state_reg == ST_DATA) && HREADY;

  always_comb begin
    state_next  = state_reg;
    cmd_ready   = 1'b0;
    htrans_next = HTRANS_IDLE;
    hwdata_next = '0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && legal) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        htrans_next = HTRANS_NONSEQ;
        if (HREADY) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (write_reg) hwdata_next = wdata_lanes;
        if (HREADY) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus-facing command fields only change for legal commands, so a rejected
  // command leaves HADDR/HWRITE/HSIZE at the last transfer's values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      write_reg     <= 1'b0;
      size_reg      <= '0;
      wdata_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= 1'b0;
      if (accept && legal) begin
        addr_reg  <= cmd_addr;
        write_reg <= cmd_write;
        size_reg  <= cmd_size;
        wdata_reg <= cmd_wdata;
      end
      if (accept && !legal) begin
        rsp_valid_reg <= 1'b1;
        rsp_err_reg   <= 1'b1;
        rsp_rdata_reg <= '0;
      end
      if (done) begin
        rsp_valid_reg <= 1'b1;
        rsp_err_reg   <= HRESP;
        rsp_rdata_reg <= (!write_reg && !HRESP) ? rdata_aligned : '0;
      end
    end
  end

  assign HTRANS    = htrans_next;
  assign HWDATA    = hwdata_next;
  assign HADDR     = addr_reg;
  assign HWRITE    = write_reg;
  assign HSIZE     = size_reg;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_ahblite_cmd_master.sv
// Randomized bench for ahblite_cmd_master: transaction-level expectations
// checked every cycle, plus literal checks on the directed transfers.
module tb_ahblite_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [2:0]  cmd_size = '0;
  logic        cmd_ready, rsp_valid, rsp_err, HWRITE, HMASTLOCK;
  logic [31:0] rsp_rdata, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1, HRESP = 1'b0;

  always #5 HCLK = ~HCLK;

  ahblite_cmd_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int n_pass = 0, n_total = 0, cyc = 0, n_tx = 0;

  // Transaction-level model state
  logic [31:0] m_haddr = '0, m_rdata = '0;
  logic        m_hwrite = 1'b0, m_err = 1'b0;
  logic [2:0]  m_hsize = '0;
  bit          resp_now = 1'b0;
  bit          chk_en = 1'b0;
  logic        e_ready, e_rsp_valid;
  logic [1:0]  e_htrans;
  logic [31:0] e_hwdata;

  // Observations for literal checks
  int          acc_cyc = 0, nonseq_cyc = 0, rsp_cyc = 0, nonseq_cnt = 0, rsp_cnt = 0;
  bit          seen_ns = 1'b0;
  logic [31:0] cap_hwdata = '0, cap_rdata = '0;
  logic        cap_err = 1'b0;
  logic [2:0]  cap_hsize = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    else n_pass++;
  endtask

  function automatic logic is_legal(input logic [2:0] sz, input logic [31:0] a);
    return (sz <= 3'd2) && ((a % (32'd1 << sz)) == 0);
  endfunction

  function automatic logic [31:0] repl(input logic [31:0] wd, input logic [2:0] sz);
    if (sz == 3'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 3'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] sz);
    int unsigned sh;
    logic [63:0] mask;
    sh   = (sz == 3'd0) ? 8 * (a % 4) : (sz == 3'd1) ? 16 * ((a / 2) % 2) : 0;
    mask = (64'd1 << (8 << sz)) - 1;
    return 32'((64'(rd) >> sh) & mask);
  endfunction

  always @(posedge HCLK) cyc++;

  always @(negedge HCLK) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
      chk("HTRANS", 32'(HTRANS), 32'(e_htrans));
      chk("HADDR", HADDR, m_haddr);
      chk("HWRITE", 32'(HWRITE), 32'(m_hwrite));
      chk("HSIZE", 32'(HSIZE), 32'(m_hsize));
      chk("HWDATA", HWDATA, e_hwdata);
      chk("HBURST", 32'(HBURST), 32'd0);
      chk("HPROT", 32'(HPROT), 32'd3);
      chk("HMASTLOCK", 32'(HMASTLOCK), 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      chk("rsp_rdata", rsp_rdata, m_rdata);
    end
    if (cmd_valid && cmd_ready) begin acc_cyc = cyc; seen_ns = 1'b0; end
    if (HTRANS == 2'b10) begin
      nonseq_cnt++;
      if (!seen_ns) begin nonseq_cyc = cyc; seen_ns = 1'b1; cap_hsize = HSIZE; end
    end
    if (HWDATA != 32'd0) cap_hwdata = HWDATA;
    if (rsp_valid) begin rsp_cnt++; rsp_cyc = cyc; cap_rdata = rsp_rdata; cap_err = rsp_err; end
  end

  task automatic cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_exp(input logic rdy, input logic [1:0] tr, input logic [31:0] wd);
    e_ready = rdy; e_htrans = tr; e_hwdata = wd;
    e_rsp_valid = resp_now;
    resp_now = 1'b0;
  endtask

  task automatic idle_cycle();
    cmd_valid = 1'b0;
    HREADY = 1'($urandom % 2); HRESP = 1'b0; HRDATA = $urandom;
    set_exp(1'b1, 2'b00, 32'd0);
    cycle();
  endtask

  task automatic noise_cmd();
    cmd_valid = 1'($urandom % 2); cmd_write = 1'($urandom % 2);
    cmd_addr = $urandom & 32'hFFFF_FFFC; cmd_size = 3'($urandom_range(0, 2));
    cmd_wdata = $urandom;
  endtask

  // Present one command in the current cycle and run it to its response cycle.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [2:0] sz,
                         input logic [31:0] wd, input int aw, input int dw,
                         input bit err, input logic [31:0] rd);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = sz; cmd_wdata = wd;
    HREADY = 1'($urandom % 2); HRESP = 1'b0; HRDATA = $urandom;
    set_exp(1'b1, 2'b00, 32'd0);
    cycle();
    n_tx++;
    if (!is_legal(sz, addr)) begin
      cmd_valid = 1'b0;
      m_err = 1'b1; m_rdata = '0; resp_now = 1'b1;
      $display("tx %0d: %s addr=0x%08h size=%0d rejected, expect rsp_err=1", n_tx, wr ? "WR" : "RD", addr, sz);
      return;
    end
    m_haddr = addr; m_hwrite = wr; m_hsize = sz;
    for (int i = 0; i <= aw; i++) begin
      noise_cmd();
      HREADY = (i == aw); HRESP = 1'b0; HRDATA = $urandom;
      set_exp(1'b0, 2'b10, 32'd0);
      cycle();
    end
    for (int j = 0; j <= dw; j++) begin
      noise_cmd();
      HREADY = (j == dw); HRESP = err && (j >= dw - 1);
      HRDATA = (j == dw) ? rd : $urandom;
      set_exp(1'b0, 2'b00, wr ? repl(wd, sz) : 32'd0);
      cycle();
    end
    cmd_valid = 1'b0; HRESP = 1'b0;
    m_err = err;
    m_rdata = (!wr && !err) ? extract(rd, addr, sz) : 32'd0;
    resp_now = 1'b1;
    $display("tx %0d: %s addr=0x%08h size=%0d wd=0x%08h aw=%0d dw=%0d err=%0b expect rdata=0x%08h",
             n_tx, wr ? "WR" : "RD", addr, sz, wd, aw, dw, err, m_rdata);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_HTRANS"}, 32'(HTRANS), 32'd0);
    chk({tag, "_HADDR"}, HADDR, 32'd0);
    chk({tag, "_HWRITE"}, 32'(HWRITE), 32'd0);
    chk({tag, "_HSIZE"}, 32'(HSIZE), 32'd0);
    chk({tag, "_HWDATA"}, HWDATA, 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_HBURST"}, 32'(HBURST), 32'd0);
    chk({tag, "_HMASTLOCK"}, 32'(HMASTLOCK), 32'd0);
    chk({tag, "_HPROT"}, 32'(HPROT), 32'd3);
  endtask

  task automatic model_reset();
    m_haddr = '0; m_hwrite = 1'b0; m_hsize = '0; m_err = 1'b0; m_rdata = '0; resp_now = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got cycle %0d expected under 10000", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    bit wr, err;
    int aw, dw, r;
    logic [2:0] sz;
    logic [31:0] a;

    repeat (3) @(posedge HCLK);
    #1;
    reset_checks("por");
    HRESETn = 1'b1;
    model_reset();
    chk_en = 1'b1;
    idle_cycle();

    // Word write, zero wait: NONSEQ at N+1, rsp at N+3
    cap_hwdata = '0;
    run_cmd(1'b1, 32'h4000_0010, 3'd2, 32'h1234_5678, 0, 0, 1'b0, 32'h0);
    idle_cycle();
    chk("w32_nonseq_lat", 32'(nonseq_cyc - acc_cyc), 32'd1);
    chk("w32_rsp_lat", 32'(rsp_cyc - acc_cyc), 32'd3);
    chk("w32_hwdata", cap_hwdata, 32'h1234_5678);
    chk("w32_err", 32'(cap_err), 32'd0);

    // Byte read from top lane with two wait states
    run_cmd(1'b0, 32'h4000_0003, 3'd0, 32'h0, 0, 2, 1'b0, 32'hAB00_0000);
    idle_cycle();
    chk("rb_rsp_lat", 32'(rsp_cyc - acc_cyc), 32'd5);
    chk("rb_rdata", cap_rdata, 32'h0000_00AB);

    // Halfword write replicated on both halves
    cap_hwdata = '0;
    run_cmd(1'b1, 32'h4000_0002, 3'd1, 32'h0000_BEEF, 0, 0, 1'b0, 32'h0);
    idle_cycle();
    chk("wh_hsize", 32'(cap_hsize), 32'd1);
    chk("wh_hwdata", cap_hwdata, 32'hBEEF_BEEF);

    // Word read with two-cycle ERROR response
    run_cmd(1'b0, 32'h4000_0020, 3'd2, 32'h0, 0, 1, 1'b1, 32'hDEAD_BEEF);
    idle_cycle();
    chk("re_err", 32'(cap_err), 32'd1);
    chk("re_rdata", cap_rdata, 32'd0);

    // Misaligned word: rejected with no bus transfer
    snap = nonseq_cnt;
    run_cmd(1'b0, 32'h4000_0001, 3'd2, 32'h0, 0, 0, 1'b0, 32'h0);
    idle_cycle();
    chk("mis_nonseq", 32'(nonseq_cnt), 32'(snap));
    chk("mis_rsp_lat", 32'(rsp_cyc - acc_cyc), 32'd1);
    chk("mis_err", 32'(cap_err), 32'd1);

    // Reset during data-phase wait
    run_cmd(1'b1, 32'h4000_0040, 3'd2, 32'hCAFE_F00D, 0, 0, 1'b0, 32'h0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0044; cmd_size = 3'd2;
    set_exp(1'b1, 2'b00, 32'd0);
    cycle();
    cmd_valid = 1'b0; m_haddr = 32'h4000_0044; m_hwrite = 1'b0; m_hsize = 3'd2;
    HREADY = 1'b1;
    set_exp(1'b0, 2'b10, 32'd0);
    cycle();
    for (int k = 0; k < 2; k++) begin
      HREADY = 1'b0;
      set_exp(1'b0, 2'b00, 32'd0);
      cycle();
    end
    chk_en = 1'b0;
    snap = rsp_cnt;
    HRESETn = 1'b0;
    #1;
    reset_checks("arst");
    HREADY = 1'b1;
    cycle();
    cycle();
    HRESETn = 1'b1;
    model_reset();
    chk_en = 1'b1;
    repeat (3) idle_cycle();
    chk("arst_no_rsp", 32'(rsp_cnt), 32'(snap));
    run_cmd(1'b0, 32'h4000_0006, 3'd1, 32'h0, 1, 1, 1'b0, 32'h1357_2468);
    idle_cycle();
    chk("arst_next_rdata", cap_rdata, 32'h0000_1357);

    // Randomized traffic, frequently back-to-back
    for (int t = 0; t < 300; t++) begin
      wr = 1'($urandom % 2);
      r  = $urandom_range(0, 15);
      sz = (r < 14) ? 3'(r % 3) : (r == 14) ? 3'd7 : 3'd3;
      a  = $urandom;
      if (sz <= 3'd2 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 1);
      aw = $urandom_range(0, 2);
      dw = $urandom_range(0, 3);
      err = (dw >= 1) && ($urandom % 4 == 0);
      run_cmd(wr, a, sz, $urandom, aw, dw, err, $urandom);
      if ($urandom % 4 == 0) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
